multicycle_main_control: RTL and testbench

Main control unit for the multicycle MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath select/enable. It produces the 2-bit `ALUOp` consumed by the ALU control decoder, which combines it with `funct` into the 4-bit ALU operation code. It sits between the instruction register's opcode field and the datapath.

---
 rtl/multicycle_main_control_if.sv | 38 +++
 rtl/multicycle_main_control.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main controller and the datapath:
// the opcode field coming from the instruction register and every datapath
// select/enable going back, plus the debug state.
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    // Controller side
    modport master (
        input  opcode,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, state
    );

    // Datapath side
    modport slave (
        output opcode,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, instr_done, illegal_op, state
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath. Moore machine that
// walks each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath select and enable from the current state. The only
// Mealy term is illegal_op, which looks at the live opcode in DECODE.
module multicycle_main_control (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_main_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] op_r;
    logic       op_legal_s;

    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    // State register and opcode capture; the opcode is latched in DECODE so
    // MEMADR can pick lw vs sw without re-reading the instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            op_r    <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                op_r <= bus.opcode;
            end else begin
                op_r <= op_r;
            end
        end
    end

    // Classify the live opcode as one of the supported instructions.
    always_comb begin
        op_legal_s = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal_s = 1'b1;
            default:                                       op_legal_s = 1'b0;
        endcase
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH:  state_nxt_s = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_EXEC;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_J:         state_nxt_s = S_JUMP;
                    OP_ADDI:      state_nxt_s = S_ADDIEX;
                    default:      state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_r == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD:  state_nxt_s = S_MEMWB;
            S_EXEC:   state_nxt_s = S_ALUWB;
            S_ADDIEX: state_nxt_s = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB,
            S_BRANCH, S_JUMP: state_nxt_s = S_FETCH;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // Moore output decode; enables and pulses are held low while reset is
    // asserted so an aborted instruction cannot write anything.
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        instr_done_s    = 1'b0;
        illegal_op_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                ir_write_s  = 1'b1;
                alu_src_b_s = 2'b01;
                pc_write_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b_s  = 2'b11;
                illegal_op_s = ~op_legal_s;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s  = 1'b1;
                iord_s       = 1'b1;
                instr_done_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
                instr_done_s    = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'b10;
                instr_done_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write_s      = 1'b0;
            pc_write_cond_s = 1'b0;
            mem_read_s      = 1'b0;
            mem_write_s     = 1'b0;
            ir_write_s      = 1'b0;
            reg_write_s     = 1'b0;
            instr_done_s    = 1'b0;
            illegal_op_s    = 1'b0;
        end else begin
            illegal_op_s = illegal_op_s;
        end
    end

    assign bus.PCWrite     = pc_write_s;
    assign bus.PCWriteCond = pc_write_cond_s;
    assign bus.IorD        = iord_s;
    assign bus.MemRead     = mem_read_s;
    assign bus.MemWrite    = mem_write_s;
    assign bus.IRWrite     = ir_write_s;
    assign bus.MemtoReg    = mem_to_reg_s;
    assign bus.RegDst      = reg_dst_s;
    assign bus.RegWrite    = reg_write_s;
    assign bus.ALUSrcA     = alu_src_a_s;
    assign bus.ALUSrcB     = alu_src_b_s;
    assign bus.ALUOp       = alu_op_s;
    assign bus.PCSource    = pc_source_s;
    assign bus.instr_done  = instr_done_s;
    assign bus.illegal_op  = illegal_op_s;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: each stimulus cycle pushes
// the hand-written expected state and control vector; a monitor on the
// falling edge pops and compares against the DUT.
module tb_multicycle_main_control;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_main_control_if bus ();

    multicycle_main_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Vector layout (17..0): PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    // IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
    // PCSource[1:0], instr_done, illegal_op
    //                                     PW    PWC   IorD  MR    MW    IRW   M2R   RD    RW    SA    SB     AOP    PCS    DN    ILL
    localparam logic [17:0] V_FETCH  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] V_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] V_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [17:0] V_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] V_MEMRD  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] V_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] V_MEMWR  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] V_EXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [17:0] V_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [17:0] V_BRANCH = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [17:0] V_JUMP   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [17:0] V_ADDIEX = V_MEMADR;
    localparam logic [17:0] V_ADDIWB = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    // Outputs forced low while reset is high
    localparam logic [17:0] EN_MASK  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    wire [17:0] act_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                           bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                           bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                           bus.PCSource, bus.instr_done, bus.illegal_op};

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (bus.state !== e.st) begin
                n_bad = n_bad + 1;
                $display("FAIL state cyc=%0d actual=%0d required=%0d", cyc, bus.state, e.st);
            end
            n_cmp = n_cmp + 1;
            if (act_vec !== e.vec) begin
                n_bad = n_bad + 1;
                $display("FAIL ctrl cyc=%0d state=%0d actual=%b required=%b", cyc, bus.state, act_vec, e.vec);
            end
            cyc = cyc + 1;
        end
    end

    // One clock of stimulus: drive inputs just after the edge and queue what
    // the outputs must look like for the rest of that cycle.
    task automatic step(input logic rst, input logic [5:0] op,
                        input logic [3:0] st, input logic [17:0] vec);
        exp_t e;
        @(posedge clk);
        #1;
        reset      = rst;
        bus.opcode = op;
        e.st  = st;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.opcode = OP_BAD;
        // Reset for two cycles: state 0, enables held low
        step(1'b1, OP_BAD, 4'd0, V_FETCH & ~EN_MASK);
        step(1'b1, OP_BAD, 4'd0, V_FETCH & ~EN_MASK);
        // lw; a different opcode is shown after DECODE to prove it is held
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_LW,  4'd1,  V_DECODE);
        step(1'b0, OP_SW,  4'd2,  V_MEMADR);
        step(1'b0, OP_SW,  4'd3,  V_MEMRD);
        step(1'b0, OP_SW,  4'd4,  V_MEMWB);
        // R-type
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_R,   4'd1,  V_DECODE);
        step(1'b0, OP_BAD, 4'd6,  V_EXEC);
        step(1'b0, OP_BAD, 4'd7,  V_ALUWB);
        // beq then j
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_BEQ, 4'd1,  V_DECODE);
        step(1'b0, OP_BAD, 4'd8,  V_BRANCH);
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_J,   4'd1,  V_DECODE);
        step(1'b0, OP_BAD, 4'd9,  V_JUMP);
        // sw; lw shown after DECODE must not divert to MEMRD
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_SW,  4'd1,  V_DECODE);
        step(1'b0, OP_LW,  4'd2,  V_MEMADR);
        step(1'b0, OP_LW,  4'd5,  V_MEMWR);
        // addi
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_ADDI,4'd1,  V_DECODE);
        step(1'b0, OP_BAD, 4'd10, V_ADDIEX);
        step(1'b0, OP_BAD, 4'd11, V_ADDIWB);
        // Illegal opcode: pulse in DECODE, straight back to FETCH
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_BAD, 4'd1,  V_DECILL);
        step(1'b0, OP_LW,  4'd0,  V_FETCH);
        // lw aborted by reset in MEMRD: no RegWrite, back to FETCH
        step(1'b0, OP_LW,  4'd1,  V_DECODE);
        step(1'b0, OP_BAD, 4'd2,  V_MEMADR);
        step(1'b1, OP_BAD, 4'd3,  V_MEMRD & ~EN_MASK);
        step(1'b0, OP_BAD, 4'd0,  V_FETCH);
        step(1'b0, OP_BAD, 4'd1,  V_DECILL);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
